// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage req/ack controller with pipeline stall, registered load data and sticky timeout error
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [15:0] op_addr,
  input  logic [15:0] op_wdata,
  output logic        stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic accept, busy_ack, last;
  assign accept = state == IDLE && op_valid;
  assign busy_ack = state == BUSY && mem_ack;
  assign last = cnt == CNT_W'(TIMEOUT - 1);
  assign stall = accept || state == BUSY || state == ERR;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (op_valid ? BUSY : IDLE) :
               state == BUSY ? (mem_ack ? DONE : (last ? ERR : BUSY)) :
               state == DONE ? IDLE : ERR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      mem_req <= state_nx == BUSY;
      err <= state_nx == ERR;
      rd_valid <= busy_ack && !mem_we;
      if (busy_ack && !mem_we) rd_data <= mem_rdata;
      if (accept) begin
        mem_addr <= {op_addr[15:1], 1'b0};
        mem_we <= op_write;
        mem_wdata <= op_wdata;
        cnt <= '0;
      end else if (state == BUSY && !mem_ack) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized and directed checks of mem_access_ctrl against a transaction-level model
module tb_mem_access_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst, op_valid, op_write, mem_ack;
  logic [15:0] op_addr, op_wdata, mem_rdata;
  logic stall, rd_valid, mem_req, mem_we, err;
  logic [15:0] rd_data, mem_addr, mem_wdata;
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd = '0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_write(op_write), .op_addr(op_addr),
    .op_wdata(op_wdata), .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; op_valid = 1'b0; op_write = 1'b0; op_addr = '0; op_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, rd_valid, mem_req, mem_we, err, rd_data, mem_addr, mem_wdata} !== 51'd0) begin
      errors++;
      $display("FAIL reset stall=%b rv=%b req=%b we=%b err=%b rd=%h addr=%h wd=%h want all zero",
               stall, rd_valid, mem_req, mem_we, err, rd_data, mem_addr, mem_wdata);
    end
  endtask
  task automatic run_op(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int delay, input logic [15:0] rdat);
    logic acked;
    logic [15:0] wa;
    wa = {a[15:1], 1'b0};
    cyc();
    op_valid = 1'b1; op_write = w; op_addr = a; op_wdata = d; mem_ack = 1'b0; mem_rdata = 16'($urandom);
    #1;
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept stall=%b req=%b rv=%b want 1 0 0", stall, mem_req, rd_valid);
    end
    acked = 1'b0;
    for (int k = 1; k <= TO && !acked; k++) begin
      cyc();
      op_valid = 1'($urandom); op_write = 1'($urandom); op_addr = 16'($urandom); op_wdata = 16'($urandom);
      acked = k == delay;
      mem_ack = acked;
      mem_rdata = acked ? rdat : 16'($urandom);
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, stall, rd_valid, err, rd_data} !== {1'b1, w, wa, 1'b1, 1'b0, 1'b0, exp_rd}) begin
        errors++;
        $display("FAIL busy k=%0d req=%b we=%b addr=%h stall=%b rv=%b err=%b rd=%h want 1 %b %h 1 0 0 %h",
                 k, mem_req, mem_we, mem_addr, stall, rd_valid, err, rd_data, w, wa, exp_rd);
      end
      if (w) begin
        checks++;
        if (mem_wdata !== d) begin
          errors++;
          $display("FAIL wdata got %h want %h", mem_wdata, d);
        end
      end
    end
    if (acked) begin
      if (!w) exp_rd = rdat;
      cyc();
      mem_ack = 1'($urandom); op_valid = 1'($urandom); mem_rdata = 16'($urandom);
      #1;
      checks++;
      if ({mem_req, stall, rd_valid, err, rd_data} !== {1'b0, 1'b0, !w, 1'b0, exp_rd}) begin
        errors++;
        $display("FAIL done req=%b stall=%b rv=%b err=%b rd=%h want 0 0 %b 0 %h",
                 mem_req, stall, rd_valid, err, rd_data, !w, exp_rd);
      end
      cyc();
      op_valid = 1'b0; mem_ack = 1'b0;
      #1;
      checks++;
      if ({mem_req, stall, rd_valid, rd_data} !== {3'b000, exp_rd}) begin
        errors++;
        $display("FAIL idle req=%b stall=%b rv=%b rd=%h want 0 0 0 %h", mem_req, stall, rd_valid, rd_data, exp_rd);
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        op_valid = 1'($urandom); mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
        #1;
        checks++;
        if ({err, stall, mem_req, rd_valid, rd_data} !== {4'b1100, exp_rd}) begin
          errors++;
          $display("FAIL err j=%0d err=%b stall=%b req=%b rv=%b rd=%h want 1 1 0 0 %h",
                   j, err, stall, mem_req, rd_valid, rd_data, exp_rd);
        end
      end
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; op_valid = 1'b0; mem_ack = 1'b0;
      exp_rd = '0;
      #1;
      checks++;
      if ({err, stall, mem_req, rd_data} !== 19'd0) begin
        errors++;
        $display("FAIL err_clear err=%b stall=%b req=%b rd=%h want 0 0 0 0", err, stall, mem_req, rd_data);
      end
    end
  endtask
  task automatic test_load();
    run_op(1'b0, 16'h1235, 16'h0000, 3, 16'hBEEF);
  endtask
  task automatic test_store();
    run_op(1'b1, 16'h0040, 16'hA5A5, 1, 16'h0000);
  endtask
  task automatic test_timeout();
    run_op(1'b0, 16'h0102, 16'h0000, TO + 1, 16'h1111);
    run_op(1'b0, 16'h0305, 16'h0000, TO, 16'h5A5A);
  endtask
  task automatic test_spurious();
    for (int i = 0; i < 3; i++) begin
      cyc();
      op_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'($urandom);
      #1;
      checks++;
      if ({mem_req, stall, rd_valid, err, rd_data} !== {4'b0000, exp_rd}) begin
        errors++;
        $display("FAIL spurious i=%0d req=%b stall=%b rv=%b err=%b rd=%h want 0 0 0 0 %h",
                 i, mem_req, stall, rd_valid, err, rd_data, exp_rd);
      end
    end
    cyc();
    mem_ack = 1'b0;
  endtask
  task automatic test_back_to_back();
    int bursts;
    logic prev;
    bursts = 0;
    prev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      op_valid = i <= 3; op_write = 1'b0; op_addr = 16'h2000 + 16'(i);
      mem_ack = mem_req; mem_rdata = 16'($urandom);
      if (mem_req) exp_rd = mem_rdata;
      #1;
      if (mem_req && !prev) bursts++;
      prev = mem_req;
      if (i == 3 || i == 4) begin
        checks++;
        if (mem_req !== (i == 4)) begin
          errors++;
          $display("FAIL b2b_req i=%0d req=%b want %b", i, mem_req, i == 4);
        end
      end
    end
    mem_ack = 1'b0;
    checks++;
    if (bursts != 2 || rd_data !== exp_rd) begin
      errors++;
      $display("FAIL b2b bursts=%0d rd=%h want 2 %h", bursts, rd_data, exp_rd);
    end
  endtask
  task automatic test_reset_mid();
    cyc();
    op_valid = 1'b1; op_write = 1'b0; op_addr = 16'h0777; mem_ack = 1'b0;
    cyc();
    op_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    exp_rd = '0;
    #1;
    checks++;
    if ({mem_req, stall, err, rd_data} !== 19'd0) begin
      errors++;
      $display("FAIL rst_mid req=%b stall=%b err=%b rd=%h want 0 0 0 0", mem_req, stall, err, rd_data);
    end
    cyc();
    mem_ack = 1'b0;
    #1;
    checks++;
    if ({mem_req, rd_valid, rd_data} !== 18'd0) begin
      errors++;
      $display("FAIL rst_mid_ack req=%b rv=%b rd=%h want 0 0 0", mem_req, rd_valid, rd_data);
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 30; n++)
      run_op(1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(1, TO + 1)), 16'($urandom));
  endtask
  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
